pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter MAX_STALL, default 16, consecutive stalled cycles before watchdog trip (legal range 2..255).
REQ-002 SHALL have parameter CNT_W, default 16, width of the performance counters.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-low; asserted when 0.
REQ-005 SHALL have port stallreq_id  input  1  load-use hazard from ID.
REQ-006 SHALL have port stallreq_ex  input  1  multi-cycle EX operation busy.
REQ-007 SHALL have port stallreq_mem  input  1  data memory not ready.
REQ-008 SHALL have port branch_i  input  1  taken branch resolved in ID this cycle.
REQ-009 SHALL have port stall_o  output  5  hold enables: [0] PC, [1] IF_ID, [2] ID_EX, [3] EX_MEM, [4] MEM_WB.
REQ-010 SHALL have port bubble_o  output  5  NOP-insert into the register of the same index (bits [1:0] always 0).
REQ-011 SHALL have port flush_o  output  1  IF_ID loads NOP next edge.
REQ-012 SHALL have port state_o  output  2  current FSM state.
REQ-013 SHALL have port stall_cnt_o  output  CNT_W  stalled-cycle count.
REQ-014 SHALL have port flush_cnt_o  output  CNT_W  flush count.
REQ-015 SHALL have port timeout_o  output  1  sticky watchdog flag.

Function
REQ-016 SHALL implement FSM states RUN=0, STALL=1, FLUSH=2, TIMEOUT=3, driven on state_o.
REQ-017 stall_o, bubble_o, flush_o SHALL be combinational from the current inputs and state (zero latency).
REQ-018 Request priority: stallreq_mem > stallreq_ex > stallreq_id > branch_i; only the winner acts.
REQ-019 mem winner: stall_o=5'b01111, bubble_o=5'b10000, flush_o=0.
REQ-020 ex winner: stall_o=5'b00111, bubble_o=5'b01000, flush_o=0.
REQ-021 id winner: stall_o=5'b00011, bubble_o=5'b00100, flush_o=0.
REQ-022 branch winner: stall_o=0, bubble_o=0, flush_o=1.
REQ-023 No request: stall_o=0, bubble_o=0, flush_o=0.
REQ-024 branch_i concurrent with any stall request SHALL be ignored that cycle (ID is frozen; branch_i re-presents on release).
REQ-025 Transitions from RUN/STALL/FLUSH: stall winner -> STALL; branch winner -> FLUSH; none -> RUN.
REQ-026 Internal 8-bit stall_run SHALL clear on any cycle without a stall request and increment on each cycle with one.
REQ-027 Stall request present and stall_run == MAX_STALL-1 SHALL make next state TIMEOUT instead of STALL.
REQ-028 TIMEOUT SHALL be absorbing until reset: stall_o=5'b11111, bubble_o=0, flush_o=0, timeout_o=1, all inputs ignored.
REQ-029 stall_cnt_o SHALL increment on each edge where stall_o != 0 in state RUN/STALL/FLUSH, saturating at all ones.
REQ-030 flush_cnt_o SHALL increment on each edge where flush_o=1, saturating at all ones.
REQ-031 Back-to-back branch_i cycles SHALL each flush and each count.

Reset
REQ-032 rst=0 at a rising edge SHALL set state RUN, stall_run 0, both counters 0, timeout_o 0, regardless of current state (including TIMEOUT or mid-stall).
REQ-033 While rst=0, stall_o, bubble_o, flush_o SHALL be forced to 0.
REQ-034 First edge with rst=1 SHALL process inputs normally.

Verification
REQ-035 Idle: rst released, all requests 0 for 10 cycles -> stall_o=0, bubble_o=0, flush_o=0, state_o=0, counters 0.
REQ-036 Priority: stallreq_id=stallreq_ex=stallreq_mem=1, branch_i=1 one cycle -> stall_o=5'b01111, bubble_o=5'b10000, flush_o=0; next state_o=1, stall_cnt_o=1, flush_cnt_o=0.
REQ-037 Load-use then branch: stallreq_id 1 cycle with branch_i held 2 cycles -> cycle1 stall_o=5'b00011, flush_o=0; cycle2 flush_o=1; after: state_o=2, stall_cnt_o=1, flush_cnt_o=1.
REQ-038 Watchdog: MAX_STALL=16, stallreq_ex held 16 cycles -> state_o=3, timeout_o=1 after 16th edge, stall_o=5'b11111, stall_cnt_o=16; 15 cycles then release -> no timeout.
REQ-039 Reset mid-operation: in TIMEOUT assert rst=0 one edge -> state_o=0, timeout_o=0, counters 0, outputs 0 during rst.
REQ-040 Saturation: CNT_W=4, 20 separate branch_i pulses -> flush_cnt_o holds 4'hF.

Source files
------------

// File: rtl/pipe_ctrl.sv
// pipe_ctrl -- hazard and stall controller for a 5-stage in-order pipeline.
//
// Resolves the competing hold/flush requests from ID, EX and MEM into
// per-register hold enables, bubble (NOP) inserts and an IF_ID flush.
// It also counts stalled and flushed cycles, and it trips a sticky watchdog
// when the pipeline has stalled for too long without a break.
//
// Parameters
//   MAX_STALL   consecutive stalled cycles before the watchdog trips (2..255)
//   CNT_W       width of the two performance counters
//
// Ports
//   clk           sole clock, rising edge
//   rst           synchronous reset, active low
//   stallreq_id   load-use hazard detected in ID
//   stallreq_ex   multi-cycle EX operation still busy
//   stallreq_mem  data memory not ready
//   branch_i      taken branch resolved in ID this cycle
//   stall_o       hold enables [0] PC, [1] IF_ID, [2] ID_EX, [3] EX_MEM, [4] MEM_WB
//   bubble_o      NOP insert into the pipeline register of the same index
//   flush_o       IF_ID loads a NOP on the next edge
//   state_o       current controller state (RUN/STALL/FLUSH/TIMEOUT)
//   stall_cnt_o   saturating count of stalled cycles
//   flush_cnt_o   saturating count of flushes
//   timeout_o     watchdog tripped; held until reset
module pipe_ctrl #(
    parameter int MAX_STALL = 16,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stallreq_id,
    input  logic             stallreq_ex,
    input  logic             stallreq_mem,
    input  logic             branch_i,
    output logic [4:0]       stall_o,
    output logic [4:0]       bubble_o,
    output logic             flush_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o,
    output logic             timeout_o
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        STALL   = 2'd1,
        FLUSH   = 2'd2,
        TIMEOUT = 2'd3
    } state_t;

    // The stall run that is one short of the limit; one more stalled cycle trips the watchdog.
    localparam logic [7:0] RUN_LIMIT = 8'(MAX_STALL - 1);

    state_t     state;
    state_t     next_state;
    logic [7:0] stall_run;
    logic       stall_any;

    assign stall_any = stallreq_mem | stallreq_ex | stallreq_id;
    assign state_o   = state;
    assign timeout_o = (state == TIMEOUT);

    // Priority resolution and next-state selection. MEM outranks EX, which outranks ID;
    // a branch only acts when nothing is stalling, because a frozen ID stage
    // re-presents the branch once the stall releases. TIMEOUT freezes the whole
    // pipe and ignores every request. Reset forces the control outputs quiet.
    always_comb begin
        stall_o    = 5'b00000;
        bubble_o   = 5'b00000;
        flush_o    = 1'b0;
        next_state = state;

        if (state == TIMEOUT) begin
            stall_o    = 5'b11111;
            next_state = TIMEOUT;
        end else begin
            if (stallreq_mem) begin
                stall_o  = 5'b01111;
                bubble_o = 5'b10000;
            end else if (stallreq_ex) begin
                stall_o  = 5'b00111;
                bubble_o = 5'b01000;
            end else if (stallreq_id) begin
                stall_o  = 5'b00011;
                bubble_o = 5'b00100;
            end else if (branch_i) begin
                flush_o = 1'b1;
            end

            if (stall_any) begin
                next_state = (stall_run == RUN_LIMIT) ? TIMEOUT : STALL;
            end else if (branch_i) begin
                next_state = FLUSH;
            end else begin
                next_state = RUN;
            end
        end

        if (!rst) begin
            stall_o  = 5'b00000;
            bubble_o = 5'b00000;
            flush_o  = 1'b0;
        end
    end

    // State register and consecutive-stall tracker. The tracker freezes in TIMEOUT
    // since that state can only be left through reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= RUN;
            stall_run <= 8'd0;
        end else begin
            state <= next_state;
            if (state != TIMEOUT) begin
                stall_run <= stall_any ? stall_run + 8'd1 : 8'd0;
            end
        end
    end

    // Performance counters saturate instead of wrapping so a long run never reads as a small one.
    // Stalls imposed by TIMEOUT itself are not counted.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            if ((stall_o != 5'b00000) && (state != TIMEOUT) && (stall_cnt_o != '1)) begin
                stall_cnt_o <= stall_cnt_o + 1'b1;
            end
            if (flush_o && (flush_cnt_o != '1)) begin
                flush_cnt_o <= flush_cnt_o + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl -- self-checking bench for pipe_ctrl.
//
// Two instances share one stimulus stream: instance A uses the default
// parameters, and instance B uses a short watchdog and 4-bit counters so that
// timeouts and saturation occur often. A behavioural model tracks each instance
// and is compared on every negative clock edge. Directed sequences pin
// hand-computed values, and a randomized phase follows them.
module tb_pipe_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic stallreq_id = 1'b0;
    logic stallreq_ex = 1'b0;
    logic stallreq_mem = 1'b0;
    logic branch_i = 1'b0;

    logic [4:0]  stall_a, bubble_a, stall_b, bubble_b;
    logic        flush_a, flush_b, timeout_a, timeout_b;
    logic [1:0]  state_a, state_b;
    logic [15:0] stall_cnt_a, flush_cnt_a;
    logic [3:0]  stall_cnt_b, flush_cnt_b;

    int checks = 0;
    int failures = 0;

    // Model state per instance: [0] = A, [1] = B.
    int max_stall_k[2] = '{16, 5};
    int cnt_max_k[2]   = '{65535, 15};
    bit m_timed[2];
    int m_run[2];
    int m_scnt[2];
    int m_fcnt[2];
    int m_st[2];
    bit model_valid = 1'b0;

    pipe_ctrl #(.MAX_STALL(16), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst),
        .stallreq_id(stallreq_id), .stallreq_ex(stallreq_ex),
        .stallreq_mem(stallreq_mem), .branch_i(branch_i),
        .stall_o(stall_a), .bubble_o(bubble_a), .flush_o(flush_a),
        .state_o(state_a), .stall_cnt_o(stall_cnt_a),
        .flush_cnt_o(flush_cnt_a), .timeout_o(timeout_a)
    );

    pipe_ctrl #(.MAX_STALL(5), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst),
        .stallreq_id(stallreq_id), .stallreq_ex(stallreq_ex),
        .stallreq_mem(stallreq_mem), .branch_i(branch_i),
        .stall_o(stall_b), .bubble_o(bubble_b), .flush_o(flush_b),
        .state_o(state_b), .stall_cnt_o(stall_cnt_b),
        .flush_cnt_o(flush_cnt_b), .timeout_o(timeout_b)
    );

    always #5 clk = ~clk;

    // Record one comparison; a mismatch prints a single FAIL line.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle's inputs just after the rising edge.
    task automatic applyStimulus(input bit r, input bit id, input bit ex,
                                 input bit mem, input bit br);
        @(posedge clk);
        #1;
        rst          = r;
        stallreq_id  = id;
        stallreq_ex  = ex;
        stallreq_mem = mem;
        branch_i     = br;
    endtask

    // Expected {stall, bubble, flush} from the priority table.
    function automatic logic [10:0] exp_comb(bit r, bit timed, bit id, bit ex, bit mem, bit br);
        if (!r)        return 11'b0;
        if (timed)     return {5'b11111, 5'b00000, 1'b0};
        if (mem)       return {5'b01111, 5'b10000, 1'b0};
        if (ex)        return {5'b00111, 5'b01000, 1'b0};
        if (id)        return {5'b00011, 5'b00100, 1'b0};
        if (br)        return {5'b00000, 5'b00000, 1'b1};
        return 11'b0;
    endfunction

    // Advance the behavioural model with the inputs present at this edge.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst) begin
                m_timed[k] = 1'b0;
                m_run[k]   = 0;
                m_scnt[k]  = 0;
                m_fcnt[k]  = 0;
                m_st[k]    = 0;
            end else if (!m_timed[k]) begin
                if (stallreq_mem || stallreq_ex || stallreq_id) begin
                    m_scnt[k] = (m_scnt[k] < cnt_max_k[k]) ? m_scnt[k] + 1 : m_scnt[k];
                    m_run[k]  = m_run[k] + 1;
                    if (m_run[k] >= max_stall_k[k]) begin
                        m_timed[k] = 1'b1;
                        m_st[k]    = 3;
                    end else begin
                        m_st[k] = 1;
                    end
                end else begin
                    m_run[k] = 0;
                    if (branch_i) begin
                        m_fcnt[k] = (m_fcnt[k] < cnt_max_k[k]) ? m_fcnt[k] + 1 : m_fcnt[k];
                        m_st[k]   = 2;
                    end else begin
                        m_st[k] = 0;
                    end
                end
            end
        end
        if (!rst) model_valid = 1'b1;
    end

    // Compare both instances against the model on every falling edge.
    always @(negedge clk) begin
        if (model_valid) begin
            logic [10:0] ea, eb;
            ea = exp_comb(rst, m_timed[0], stallreq_id, stallreq_ex, stallreq_mem, branch_i);
            eb = exp_comb(rst, m_timed[1], stallreq_id, stallreq_ex, stallreq_mem, branch_i);
            checkOutput("a_stall",   32'(stall_a),     32'(ea[10:6]));
            checkOutput("a_bubble",  32'(bubble_a),    32'(ea[5:1]));
            checkOutput("a_flush",   32'(flush_a),     32'(ea[0]));
            checkOutput("a_state",   32'(state_a),     32'(m_st[0]));
            checkOutput("a_timeout", 32'(timeout_a),   32'(m_timed[0]));
            checkOutput("a_scnt",    32'(stall_cnt_a), 32'(m_scnt[0]));
            checkOutput("a_fcnt",    32'(flush_cnt_a), 32'(m_fcnt[0]));
            checkOutput("b_stall",   32'(stall_b),     32'(eb[10:6]));
            checkOutput("b_bubble",  32'(bubble_b),    32'(eb[5:1]));
            checkOutput("b_flush",   32'(flush_b),     32'(eb[0]));
            checkOutput("b_state",   32'(state_b),     32'(m_st[1]));
            checkOutput("b_timeout", 32'(timeout_b),   32'(m_timed[1]));
            checkOutput("b_scnt",    32'(stall_cnt_b), 32'(m_scnt[1]));
            checkOutput("b_fcnt",    32'(flush_cnt_b), 32'(m_fcnt[1]));
        end
    end

    // Directed sequences with literal expectations, then a randomized phase.
    initial begin
        int ex_hold;
        int r;

        // Reset with every request asserted: outputs must stay quiet.
        applyStimulus(0, 1, 1, 1, 1);
        applyStimulus(0, 1, 1, 1, 1);
        @(negedge clk);
        checkOutput("rst_stall",  32'(stall_a),  32'h0);
        checkOutput("rst_bubble", 32'(bubble_a), 32'h0);
        checkOutput("rst_flush",  32'(flush_a),  32'h0);

        // Idle for 10 cycles.
        for (int i = 0; i < 10; i++) applyStimulus(1, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("idle_state", 32'(state_a),     32'h0);
        checkOutput("idle_stall", 32'(stall_a),     32'h0);
        checkOutput("idle_scnt",  32'(stall_cnt_a), 32'h0);
        checkOutput("idle_fcnt",  32'(flush_cnt_a), 32'h0);

        // All requests at once: MEM wins.
        applyStimulus(1, 1, 1, 1, 1);
        @(negedge clk);
        checkOutput("prio_stall",  32'(stall_a),  32'h0f);
        checkOutput("prio_bubble", 32'(bubble_a), 32'h10);
        checkOutput("prio_flush",  32'(flush_a),  32'h0);
        applyStimulus(1, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("prio_state", 32'(state_a),     32'h1);
        checkOutput("prio_scnt",  32'(stall_cnt_a), 32'h1);
        checkOutput("prio_fcnt",  32'(flush_cnt_a), 32'h0);

        // Load-use hazard, then the held branch takes effect.
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(1, 1, 0, 0, 1);
        @(negedge clk);
        checkOutput("lu_stall", 32'(stall_a), 32'h03);
        checkOutput("lu_flush", 32'(flush_a), 32'h0);
        applyStimulus(1, 0, 0, 0, 1);
        @(negedge clk);
        checkOutput("br_flush", 32'(flush_a), 32'h1);
        applyStimulus(1, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("br_state", 32'(state_a),     32'h2);
        checkOutput("br_scnt",  32'(stall_cnt_a), 32'h1);
        checkOutput("br_fcnt",  32'(flush_cnt_a), 32'h1);

        // A 15-cycle stall releases without tripping the watchdog.
        applyStimulus(0, 0, 0, 0, 0);
        for (int i = 0; i < 15; i++) applyStimulus(1, 0, 1, 0, 0);
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("wd15_state",   32'(state_a),     32'h0);
        checkOutput("wd15_timeout", 32'(timeout_a),   32'h0);
        checkOutput("wd15_scnt",    32'(stall_cnt_a), 32'd15);

        // A 16-cycle stall trips it; TIMEOUT then ignores all inputs.
        applyStimulus(0, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++) applyStimulus(1, 0, 1, 0, 0);
        applyStimulus(1, 0, 0, 0, 1);
        @(negedge clk);
        checkOutput("wd16_state",   32'(state_a),     32'h3);
        checkOutput("wd16_timeout", 32'(timeout_a),   32'h1);
        checkOutput("wd16_stall",   32'(stall_a),     32'h1f);
        checkOutput("wd16_flush",   32'(flush_a),     32'h0);
        checkOutput("wd16_scnt",    32'(stall_cnt_a), 32'd16);
        applyStimulus(1, 1, 1, 1, 0);
        applyStimulus(1, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("wd_hold_state", 32'(state_a),     32'h3);
        checkOutput("wd_hold_scnt",  32'(stall_cnt_a), 32'd16);

        // Reset out of TIMEOUT.
        applyStimulus(0, 0, 1, 0, 1);
        @(negedge clk);
        checkOutput("rto_stall_during", 32'(stall_a), 32'h0);
        applyStimulus(1, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("rto_state",   32'(state_a),     32'h0);
        checkOutput("rto_timeout", 32'(timeout_a),   32'h0);
        checkOutput("rto_scnt",    32'(stall_cnt_a), 32'h0);
        checkOutput("rto_fcnt",    32'(flush_cnt_a), 32'h0);

        // Back-to-back branches flush each cycle.
        applyStimulus(1, 0, 0, 0, 1);
        applyStimulus(1, 0, 0, 0, 1);
        applyStimulus(1, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("b2b_fcnt", 32'(flush_cnt_a), 32'd2);

        // 20 separate branch pulses saturate the 4-bit counter.
        applyStimulus(0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1, 0, 0, 0, 1);
            applyStimulus(1, 0, 0, 0, 0);
        end
        @(negedge clk);
        checkOutput("sat_fcnt_b", 32'(flush_cnt_b), 32'hf);
        checkOutput("sat_fcnt_a", 32'(flush_cnt_a), 32'd20);

        // Randomized traffic with occasional long EX stalls and resets.
        ex_hold = 0;
        for (int i = 0; i < 3000; i++) begin
            bit rv, idv, exv, memv, brv;
            r    = $urandom_range(0, 99);
            rv   = (r >= 2);
            if (ex_hold > 0) begin
                ex_hold--;
                exv = 1'b1;
            end else if ($urandom_range(0, 99) < 4) begin
                ex_hold = $urandom_range(1, 20);
                exv = 1'b1;
            end else begin
                exv = 1'b0;
            end
            idv  = ($urandom_range(0, 99) < 15);
            memv = ($urandom_range(0, 99) < 8);
            brv  = ($urandom_range(0, 99) < 30);
            applyStimulus(rv, idv, exv, memv, brv);
        end

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
